// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - read sequencer for a message RAM with a 2-entry skid FIFO
//
// Walks a block of consecutive RAM addresses on a start command, issues one
// read per word, absorbs the RAM's 1-cycle registered read latency and
// delivers the words in address order on a valid/ready stream.
//
// Ports:
//   rdclk, rst          clock (RAM read clock), synchronous active-high reset
//   start, base_addr,   command strobe (sampled in IDLE only), first address,
//   len                 word count (0..MEMDEPTH)
//   busy, done, err     command in progress, completion pulse, reject pulse
//   RA, rd_in           RAM read address and read enable
//   ram_dout            RAM data, valid the cycle after rd_in
//   m_data, m_valid,    output stream
//   m_ready
//
// Build option: RSR_WRAP_EN - when defined, a block running past MEMDEPTH-1
// wraps to address 0; when undefined such a command is rejected with err.

module ram_stream_reader #(
   parameter int WIDTH        = 6,
   parameter int ADDRESSWIDTH = 9,
   parameter int MEMDEPTH     = 512,
   parameter int LENWIDTH     = 10
) (
   input  logic                    rdclk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDRESSWIDTH-1:0] base_addr,
   input  logic [LENWIDTH-1:0]     len,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [ADDRESSWIDTH-1:0] RA,
   output logic                    rd_in,
   input  logic [WIDTH-1:0]        ram_dout,
   output logic [WIDTH-1:0]        m_data,
   output logic                    m_valid,
   input  logic                    m_ready
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

   state_t state, state_nxt;

   logic [ADDRESSWIDTH-1:0] addr;
   logic [ADDRESSWIDTH-1:0] ra_hold;
   logic [LENWIDTH-1:0]     remaining;
   logic                    inflight;
   logic [1:0]              count;
   logic                    wr_ptr, rd_ptr;
   logic [WIDTH-1:0]        fifo_mem [2];
   logic                    done_cmd, err_cmd;
   logic                    pop, push, drain_done;
   logic                    len_zero, len_bad, span_bad, cmd_ok;
   logic [2:0]              occ;

   assign len_zero = (len == '0);
   assign len_bad  = (len > LENWIDTH'(MEMDEPTH));

`ifdef RSR_WRAP_EN
   assign span_bad = 1'b0;
`else
   localparam int SW = ((ADDRESSWIDTH > LENWIDTH) ? ADDRESSWIDTH : LENWIDTH) + 1;
   logic [SW-1:0] span_end;
   assign span_end = SW'(base_addr) + SW'(len);
   assign span_bad = (span_end > SW'(MEMDEPTH));
`endif

   assign cmd_ok = !len_zero && !len_bad && !span_bad;

   assign push    = inflight;
   assign pop     = m_valid && m_ready;
   assign m_valid = (count != 2'd0);
   assign m_data  = fifo_mem[rd_ptr];

   // Only finish once nothing is queued and no RAM word is still on its way.
   assign drain_done = (state == S_DRAIN) && !inflight && (count == 2'd0);

   // State register
   always_ff @(posedge rdclk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start && cmd_ok) state_nxt = S_READ;
         S_READ:  if (rd_in && (remaining == LENWIDTH'(1))) state_nxt = S_DRAIN;
         S_DRAIN: if (drain_done) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      // Occupancy after this cycle's pop, counting the word still in the RAM;
      // issuing only below 2 keeps the 2-entry FIFO from overflowing.
      occ   = {1'b0, count} + {2'b00, inflight};
      rd_in = (state == S_READ) && (remaining != '0) &&
              ((occ - {2'b00, pop}) < 3'd2);
      RA    = rd_in ? addr : ra_hold;
      busy  = (state != S_IDLE);
      done  = done_cmd || drain_done;
      err   = err_cmd;
   end

   // Datapath: address walk, RAM capture, skid FIFO
   always_ff @(posedge rdclk) begin
      if (rst) begin
         addr        <= '0;
         ra_hold     <= '0;
         remaining   <= '0;
         inflight    <= 1'b0;
         count       <= 2'd0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         done_cmd    <= 1'b0;
         err_cmd     <= 1'b0;
      end else begin
         done_cmd <= (state == S_IDLE) && start && len_zero;
         err_cmd  <= (state == S_IDLE) && start && !len_zero && (len_bad || span_bad);
         inflight <= rd_in;
         ra_hold  <= RA;

         if ((state == S_IDLE) && start && cmd_ok) begin
            addr      <= base_addr;
            remaining <= len;
         end else if (rd_in) begin
            // MEMDEPTH need not be a power of two, so wrap explicitly.
            addr      <= (addr == ADDRESSWIDTH'(MEMDEPTH - 1)) ? '0
                                                               : addr + ADDRESSWIDTH'(1);
            remaining <= remaining - LENWIDTH'(1);
         end

         if (push) begin
            fifo_mem[wr_ptr] <= ram_dout;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;

         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule
